// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the iterative multiply/divide unit.
//   state_t : FSM states (IDLE, MUL, DIV, DONE)
//   op_t    : which operation a start pulse requests
//   BOOTH_* : radix-2 Booth recoding of {q[i], q[i-1]}
package multdiv_pkg;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   typedef enum logic {OP_MUL, OP_DIV} op_t;

   localparam logic [1:0] BOOTH_HOLD0 = 2'b00;
   localparam logic [1:0] BOOTH_ADD   = 2'b01;
   localparam logic [1:0] BOOTH_SUB   = 2'b10;
   localparam logic [1:0] BOOTH_HOLD1 = 2'b11;

endpackage

// File: rtl/multdiv_unit_addsub_n.sv
// addsub_n: N-bit adder/subtractor.
//   a, b  : operands
//   sub   : 1 -> a - b, 0 -> a + b
//   sum   : N-bit result
//   cout  : carry out; when subtracting, 1 means a >= b (unsigned, no borrow)
module addsub_n #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] full;

   assign full = {1'b0, a} + {1'b0, b ^ {N{sub}}} + {{N{1'b0}}, sub};
   assign sum  = full[N-1:0];
   assign cout = full[N];

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply (radix-2 Booth) / divide (restoring).
// A start pulse latches the operands; result, exception and a one-cycle ready
// strobe appear WIDTH+1 cycles later. A new start aborts any operation in flight.
//   clock, reset_n              : clock, asynchronous active-low reset
//   data_operandA/B             : multiplicand/dividend, multiplier/divisor
//   ctrl_MULT / ctrl_DIV        : start pulses (MULT has priority)
//   data_result, data_exception : held from one completion to the next
//   data_resultRDY              : one-cycle completion strobe
//   busy                        : operation in flight
module multdiv_unit
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH:0]   prod_q;   // {hi, lo, q[-1]}; multiplier sits in lo
   logic [WIDTH-1:0]   rem_q;    // divide remainder
   logic [WIDTH-1:0]   quo_q;    // dividend magnitude shifting out, quotient shifting in
   logic [WIDTH-1:0]   opb_q;    // multiplicand (MUL) or divisor magnitude (DIV)
   logic               neg_q, dz_q, ovf_q;
   logic [WIDTH-1:0]   result_q;
   logic               exc_q, rdy_q;

   logic               start;
   op_t                start_op;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     add_a, add_b, add_sum;
   logic               add_sub, add_cout;
   logic               mul_exc;
   logic [WIDTH-1:0]   div_res;

   assign start    = ctrl_MULT | ctrl_DIV;
   assign start_op = ctrl_MULT ? OP_MUL : OP_DIV;
   // |-2^(W-1)| = 2^(W-1) is still representable as an unsigned WIDTH-bit value
   assign abs_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign abs_b    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

   // Single shared adder: Booth add/subtract on the sign-extended high half,
   // or the restoring trial subtract of the divisor from the shifted remainder.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_sub = 1'b0;
      if (state_q == DIV) begin
         add_a   = {rem_q, quo_q[WIDTH-1]};
         add_b   = {1'b0, opb_q};
         add_sub = 1'b1;
      end else begin
         add_a = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
         case (prod_q[1:0])
            BOOTH_ADD: add_b = {opb_q[WIDTH-1], opb_q};
            BOOTH_SUB: begin
               add_b   = {opb_q[WIDTH-1], opb_q};
               add_sub = 1'b1;
            end
            default: add_b = '0;
         endcase
      end
   end

   addsub_n #(.N(WIDTH + 1)) u_addsub (
      .a    (add_a),
      .b    (add_b),
      .sub  (add_sub),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Product fits in WIDTH signed bits only if bits [2W-1:W-1] are all equal.
   assign mul_exc = ~(&prod_q[2*WIDTH:WIDTH] | ~(|prod_q[2*WIDTH:WIDTH]));
   assign div_res = neg_q ? -quo_q : quo_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         prod_q   <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         opb_q    <= '0;
         neg_q    <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else if (start) begin
         state_q <= (start_op == OP_MUL) ? MUL : DIV;
         cnt_q   <= '0;
         rdy_q   <= 1'b0;
         prod_q  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
         rem_q   <= '0;
         quo_q   <= abs_a;
         opb_q   <= (start_op == OP_MUL) ? data_operandA : abs_b;
         neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         dz_q    <= (data_operandB == '0);
         ovf_q   <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
      end else begin
         case (state_q)
            MUL: begin
               if (cnt_q == CNT_W'(WIDTH)) begin
                  state_q  <= DONE;
                  result_q <= prod_q[WIDTH:1];
                  exc_q    <= mul_exc;
                  rdy_q    <= 1'b1;
               end else begin
                  // add/sub then arithmetic shift right by one
                  prod_q <= {add_sum, prod_q[WIDTH:1]};
                  cnt_q  <= cnt_q + CNT_W'(1);
               end
            end
            DIV: begin
               if (cnt_q == CNT_W'(WIDTH)) begin
                  state_q  <= DONE;
                  result_q <= dz_q ? '0 : div_res;
                  exc_q    <= dz_q | ovf_q;
                  rdy_q    <= 1'b1;
               end else begin
                  // cout=1: shifted remainder >= divisor, keep the difference
                  if (add_cout) begin
                     rem_q <= add_sum[WIDTH-1:0];
                     quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                  end else begin
                     rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                     quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                  end
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               rdy_q   <= 1'b0;
            end
            default: rdy_q <= 1'b0;
         endcase
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = (state_q == MUL) || (state_q == DIV);

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

- Parametrised, iterative signed multiply/divide unit.
- Sits beside the single-cycle ALU in the execute stage and handles the MUL and DIV operations that the ALU does not implement.
- Operands are accepted on a one-cycle control pulse. The result, an exception flag and a one-cycle ready strobe appear a fixed number of cycles later.
- While the unit is busy, the pipeline stalls on `busy`.

## Interface

Parameters:
- `WIDTH`, default 32: operand and result width in bits. Must be ≥ 4.
- `CNT_W`, default `$clog2(WIDTH+1)`: iteration counter width. Derived; do not override.

Ports:
- `clock` in 1: single clock. All state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `data_operandA` in WIDTH: multiplicand or dividend, two's complement.
- `data_operandB` in WIDTH: multiplier or divisor, two's complement.
- `ctrl_MULT` in 1: one-cycle pulse; starts a multiply.
- `ctrl_DIV` in 1: one-cycle pulse; starts a divide.
- `data_result` out WIDTH: product (low WIDTH bits) or quotient.
- `data_exception` out 1: overflow or divide-by-zero. Valid while `data_resultRDY`=1 and held afterwards.
- `data_resultRDY` out 1: single-cycle strobe; result is valid.
- `busy` out 1: high while an operation is in flight.

## Operation

States:
- IDLE
- MUL: Booth iterations
- DIV: restoring iterations
- DONE: one cycle, strobe

Transitions:
- From any state, a sampled `ctrl_MULT` moves to MUL. Otherwise a sampled `ctrl_DIV` moves to DIV.
- Both controls high in the same cycle: MULT wins; DIV is ignored.
- On start: latch both operands, clear the iteration counter, deassert `data_resultRDY`.
- A start while in MUL or DIV aborts the current operation. No strobe is issued for the aborted operation, and the new operation starts with full latency.
- MUL/DIV → DONE when the counter reaches WIDTH. DONE → IDLE on the next cycle.

Multiply:
- Radix-2 Booth over a (2·WIDTH+1)-bit product register, one bit per cycle, WIDTH cycles.
- `data_result` = product[WIDTH-1:0].
- `data_exception` = 1 if product bits [2W-1:W-1] are not all equal, i.e. the full product does not fit in a WIDTH-bit signed value.

Divide:
- Operate on magnitudes with a (WIDTH+1)-bit remainder accumulator, one quotient bit per cycle, WIDTH cycles.
- Negate the quotient in the DONE transition if the operand signs differ. Truncate toward zero; the remainder is not exported.
- Divisor = 0: `data_result`=0, `data_exception`=1, same latency.
- Dividend = −2^(W−1) and divisor = −1: `data_result`=−2^(W−1) (wraps), `data_exception`=1.
- All other divides: `data_exception`=0.

Outputs:
- `data_result` and `data_exception` update only on entry to DONE and hold until the next DONE or reset.
- Inputs are ignored except in the cycle a start is sampled.

## Timing

- The start is sampled at edge T0.
- `busy`=1 from T0 through T0+WIDTH; `busy`=0 in DONE.
- `data_resultRDY`=1 for exactly the cycle following edge T0+WIDTH+1. Latency is WIDTH+1 cycles (33 for WIDTH=32), independent of operand values.
- A new start may be sampled in the DONE cycle. The strobe for the completed operation still fires in that cycle.
- Reset, asynchronous on `reset_n` low:
  - state IDLE, counter 0
  - `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0
- Reset asserted mid-operation drops the operation with no strobe. After release the unit waits in IDLE for a control pulse.

## Structure

- Package `multdiv_pkg`:
  - `state_t` enum (IDLE, MUL, DIV, DONE)
  - `op_t` enum (OP_MUL, OP_DIV)
  - Booth recode constants (00/11 hold, 01 add, 10 subtract)
- One sub-module `addsub_n` (parameter N, inputs `a`, `b`, `sub`; outputs `sum`, `cout`). Instantiated once at N=WIDTH+1 and shared by the Booth add/subtract and the divide trial subtract.
- The top level holds the FSM, counter, operand/product/remainder registers and the sign fix-up.

## Test plan

Run at WIDTH=32, plus a sweep at WIDTH=8; check against a `$signed` reference model.

1. MULT A=7, B=−6 → `data_result`=−42, exception 0, `data_resultRDY` high exactly 33 cycles after the start edge, `busy` low in that cycle.
2. MULT A=0x4000_0000, B=4 → `data_result`=0, exception 1. MULT A=−2^31, B=1 → `data_result`=0x8000_0000, exception 0.
3. DIV A=−100, B=7 → `data_result`=−14, exception 0. DIV A=100, B=−7 → −14. DIV A=6, B=7 → 0.
4. DIV A=5, B=0 → `data_result`=0, exception 1. DIV A=0x8000_0000, B=−1 → `data_result`=0x8000_0000, exception 1. Both at 33-cycle latency.
5. MULT 3×3, then DIV 9/3 pulsed 10 cycles later → exactly one strobe, 33 cycles after the DIV start, with `data_result`=3. Both controls pulsed together with A=4, B=2 → `data_result`=8.
6. Start MULT, drive `reset_n` low at cycle 5 → all outputs 0 immediately, no strobe. After release, DIV 20/4 → `data_result`=5 after 33 cycles.
